// File: rtl/scoreboard_pkg.sv
// Shared encodings for the cmd_id -> proc_id scoreboard.
//   op_e     : request opcode (lookup / insert / remove)
//   status_e : response status (ok / updated / miss / full)
//   idx_width: index width helper that never collapses to zero bits
package scoreboard_pkg;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'd0,
        OP_INSERT = 2'd1,
        OP_REMOVE = 2'd2
    } op_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_UPDATED = 2'd1,
        ST_MISS    = 2'd2,
        ST_FULL    = 2'd3
    } status_e;

    // Width needed to index n items, minimum one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sb_scan_group.sv
// Combinational compare of one scan group (LANES entries) against a key.
//   i_key       : key being searched
//   i_keys      : cmd_id of each lane in the group
//   i_valid     : valid bit of each lane
//   o_hit       : some valid lane matches the key
//   o_hit_lane  : lowest matching lane
//   o_free      : some lane is invalid
//   o_free_lane : lowest invalid lane
module sb_scan_group
    import scoreboard_pkg::*;
#(
    parameter int unsigned LANES = 1,
    parameter int unsigned CMD_W = 8
) (
    input  logic [CMD_W-1:0]             i_key,
    input  logic [LANES-1:0][CMD_W-1:0]  i_keys,
    input  logic [LANES-1:0]             i_valid,
    output logic                         o_hit,
    output logic [idx_width(LANES)-1:0]  o_hit_lane,
    output logic                         o_free,
    output logic [idx_width(LANES)-1:0]  o_free_lane
);

    localparam int unsigned LW = idx_width(LANES);

    // Walk from the top lane down so the lowest matching lane is the last writer.
    always_comb begin
        o_hit       = 1'b0;
        o_hit_lane  = '0;
        o_free      = 1'b0;
        o_free_lane = '0;
        for (int i = int'(LANES) - 1; i >= 0; i--) begin
            if (i_valid[i] && (i_keys[i] == i_key)) begin
                o_hit      = 1'b1;
                o_hit_lane = LW'(i);
            end
            if (!i_valid[i]) begin
                o_free      = 1'b1;
                o_free_lane = LW'(i);
            end
        end
    end

endmodule

// File: rtl/cmd_scoreboard.sv
// cmd_id -> proc_id scoreboard with lookup / insert / remove requests.
// Entries are scanned LANES at a time; a response strobe follows each accepted
// request unless a flush aborts it.
//   i_clk / i_rstn        : clock, synchronous active-low reset
//   i_flush               : clear all entries, abort in-flight request
//   i_req_*/o_req_ready   : request handshake (op, key, value)
//   o_rsp_*               : one-cycle response (status, hit, proc, index)
//   o_count/o_full/o_empty: occupancy
module cmd_scoreboard
    import scoreboard_pkg::*;
#(
    parameter int unsigned ENTRIES = 4,
    parameter int unsigned LANES   = 1,
    parameter int unsigned CMD_W   = 8,
    parameter int unsigned PROC_W  = 2
) (
    input  logic                            i_clk,
    input  logic                            i_rstn,
    input  logic                            i_flush,
    input  logic                            i_req_valid,
    output logic                            o_req_ready,
    input  op_e                             i_req_op,
    input  logic [CMD_W-1:0]                i_req_cmd,
    input  logic [PROC_W-1:0]               i_req_proc,
    output logic                            o_rsp_valid,
    output status_e                         o_rsp_status,
    output logic                            o_rsp_hit,
    output logic [PROC_W-1:0]               o_rsp_proc,
    output logic [idx_width(ENTRIES)-1:0]   o_rsp_idx,
    output logic [$clog2(ENTRIES+1)-1:0]    o_count,
    output logic                            o_full,
    output logic                            o_empty
);

    localparam int unsigned G     = ENTRIES / LANES;
    localparam int unsigned IDX_W = idx_width(ENTRIES);
    localparam int unsigned CNT_W = $clog2(ENTRIES + 1);
    localparam int unsigned GW    = idx_width(G);
    localparam int unsigned LW    = idx_width(LANES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd_id;
        logic [PROC_W-1:0] proc_id;
    } entry_t;

    if ((ENTRIES % LANES) != 0) begin : g_bad_cfg
        $error("cmd_scoreboard: ENTRIES (%0d) must be a multiple of LANES (%0d)", ENTRIES, LANES);
    end

    // Control state
    logic [1:0]          state_q, state_d;
    logic [GW-1:0]       ptr_q, ptr_d;
    op_e                 op_q, op_d;
    logic [CMD_W-1:0]    cmd_q, cmd_d;
    logic [PROC_W-1:0]   proc_q, proc_d;
    logic                hit_found_q, hit_found_d;
    logic [IDX_W-1:0]    hit_idx_q, hit_idx_d;
    logic                free_found_q, free_found_d;
    logic [IDX_W-1:0]    free_idx_q, free_idx_d;

    // Storage
    logic [ENTRIES-1:0]  valid_q, valid_d;
    entry_t              entries_q [ENTRIES];
    entry_t              entries_d [ENTRIES];
    logic [CNT_W-1:0]    count_q, count_d;

    // Response registers
    logic                rsp_valid_q, rsp_valid_d;
    status_e             rsp_status_q, rsp_status_d;
    logic                rsp_hit_q, rsp_hit_d;
    logic [PROC_W-1:0]   rsp_proc_q, rsp_proc_d;
    logic [IDX_W-1:0]    rsp_idx_q, rsp_idx_d;

    // Scan datapath
    logic [IDX_W-1:0]               grp_base;
    logic [LANES-1:0][CMD_W-1:0]    grp_keys;
    logic [LANES-1:0]               grp_valid;
    logic                           scan_hit;
    logic [LW-1:0]                  scan_hit_lane;
    logic                           scan_free;
    logic [LW-1:0]                  scan_free_lane;
    logic                           accept;
    logic                           last_grp;

    assign o_req_ready = (state_q == S_IDLE) && !i_flush && i_rstn;
    assign accept      = i_req_valid && o_req_ready;
    assign last_grp    = (ptr_q == GW'(G - 1));

    // Gather the group currently pointed at.
    always_comb begin
        grp_base = IDX_W'(32'(ptr_q) * LANES);
        for (int l = 0; l < int'(LANES); l++) begin
            grp_keys[l]  = entries_q[grp_base + IDX_W'(l)].cmd_id;
            grp_valid[l] = valid_q[grp_base + IDX_W'(l)];
        end
    end

    sb_scan_group #(
        .LANES (LANES),
        .CMD_W (CMD_W)
    ) u_scan (
        .i_key       (cmd_q),
        .i_keys      (grp_keys),
        .i_valid     (grp_valid),
        .o_hit       (scan_hit),
        .o_hit_lane  (scan_hit_lane),
        .o_free      (scan_free),
        .o_free_lane (scan_free_lane)
    );

    // Next-state, scan bookkeeping and response/update logic.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        op_d         = op_q;
        cmd_d        = cmd_q;
        proc_d       = proc_q;
        hit_found_d  = hit_found_q;
        hit_idx_d    = hit_idx_q;
        free_found_d = free_found_q;
        free_idx_d   = free_idx_q;
        valid_d      = valid_q;
        entries_d    = entries_q;
        count_d      = count_q;
        rsp_valid_d  = 1'b0;
        rsp_status_d = ST_OK;
        rsp_hit_d    = 1'b0;
        rsp_proc_d   = '0;
        rsp_idx_d    = '0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d         = i_req_op;
                    cmd_d        = i_req_cmd;
                    proc_d       = i_req_proc;
                    ptr_d        = '0;
                    hit_found_d  = 1'b0;
                    hit_idx_d    = '0;
                    free_found_d = 1'b0;
                    free_idx_d   = '0;
                    state_d      = S_SCAN;
                end
            end

            S_SCAN: begin
                // Groups are visited in ascending order, so the first record is the lowest.
                if (scan_hit && !hit_found_q) begin
                    hit_found_d = 1'b1;
                    hit_idx_d   = grp_base + IDX_W'(scan_hit_lane);
                end
                if (scan_free && !free_found_q) begin
                    free_found_d = 1'b1;
                    free_idx_d   = grp_base + IDX_W'(scan_free_lane);
                end
                // Insert must see every group to rule out an existing copy of the key.
                if (((op_q != OP_INSERT) && scan_hit) || last_grp) begin
                    state_d = S_RESP;
                end else begin
                    ptr_d = ptr_q + GW'(1);
                end
            end

            S_RESP: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b1;
                case (op_q)
                    OP_LOOKUP: begin
                        if (hit_found_q) begin
                            rsp_status_d = ST_OK;
                            rsp_hit_d    = 1'b1;
                            rsp_proc_d   = entries_q[hit_idx_q].proc_id;
                            rsp_idx_d    = hit_idx_q;
                        end else begin
                            rsp_status_d = ST_MISS;
                        end
                    end
                    OP_INSERT: begin
                        if (hit_found_q) begin
                            entries_d[hit_idx_q].proc_id = proc_q;
                            rsp_status_d = ST_UPDATED;
                            rsp_hit_d    = 1'b1;
                            rsp_idx_d    = hit_idx_q;
                        end else if (free_found_q) begin
                            entries_d[free_idx_q].cmd_id  = cmd_q;
                            entries_d[free_idx_q].proc_id = proc_q;
                            valid_d[free_idx_q]           = 1'b1;
                            count_d      = count_q + CNT_W'(1);
                            rsp_status_d = ST_OK;
                            rsp_idx_d    = free_idx_q;
                        end else begin
                            rsp_status_d = ST_FULL;
                        end
                    end
                    OP_REMOVE: begin
                        if (hit_found_q) begin
                            valid_d[hit_idx_q] = 1'b0;
                            count_d      = count_q - CNT_W'(1);
                            rsp_status_d = ST_OK;
                            rsp_hit_d    = 1'b1;
                            rsp_idx_d    = hit_idx_q;
                        end else begin
                            rsp_status_d = ST_MISS;
                        end
                    end
                    default: begin
                        rsp_status_d = ST_MISS;
                    end
                endcase
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush wins over everything, including a response about to be issued.
        if (i_flush) begin
            state_d      = S_IDLE;
            valid_d      = '0;
            count_d      = '0;
            rsp_valid_d  = 1'b0;
            rsp_status_d = ST_OK;
            rsp_hit_d    = 1'b0;
            rsp_proc_d   = '0;
            rsp_idx_d    = '0;
        end
    end

    // Control, valid bits, occupancy and response registers.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            op_q         <= OP_LOOKUP;
            cmd_q        <= '0;
            proc_q       <= '0;
            hit_found_q  <= 1'b0;
            hit_idx_q    <= '0;
            free_found_q <= 1'b0;
            free_idx_q   <= '0;
            valid_q      <= '0;
            count_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_status_q <= ST_OK;
            rsp_hit_q    <= 1'b0;
            rsp_proc_q   <= '0;
            rsp_idx_q    <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            op_q         <= op_d;
            cmd_q        <= cmd_d;
            proc_q       <= proc_d;
            hit_found_q  <= hit_found_d;
            hit_idx_q    <= hit_idx_d;
            free_found_q <= free_found_d;
            free_idx_q   <= free_idx_d;
            valid_q      <= valid_d;
            count_q      <= count_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_status_q <= rsp_status_d;
            rsp_hit_q    <= rsp_hit_d;
            rsp_proc_q   <= rsp_proc_d;
            rsp_idx_q    <= rsp_idx_d;
        end
    end

    // Key/value storage; contents are only meaningful under a valid bit.
    always_ff @(posedge i_clk) begin
        entries_q <= entries_d;
    end

    assign o_rsp_valid  = rsp_valid_q;
    assign o_rsp_status = rsp_status_q;
    assign o_rsp_hit    = rsp_hit_q;
    assign o_rsp_proc   = rsp_proc_q;
    assign o_rsp_idx    = rsp_idx_q;
    assign o_count      = count_q;
    assign o_full       = (count_q == CNT_W'(ENTRIES));
    assign o_empty      = (count_q == '0);

endmodule

// File: tb/tb_cmd_scoreboard.sv
// Directed bench: one scoreboard with LANES=1 and one with LANES=2 (ENTRIES=4 each).
module tb_cmd_scoreboard;
    import scoreboard_pkg::*;

    logic        clk;
    logic        rstn;
    logic        flush;
    logic        v1, v2;
    op_e         op;
    logic [7:0]  cmd;
    logic [1:0]  proc;

    logic        r1_ready, r1_valid, r1_hit, r1_full, r1_empty;
    status_e     r1_status;
    logic [1:0]  r1_proc, r1_idx;
    logic [2:0]  r1_count;

    logic        r2_ready, r2_valid, r2_hit, r2_full, r2_empty;
    status_e     r2_status;
    logic [1:0]  r2_proc, r2_idx;
    logic [2:0]  r2_count;

    int          vec;
    int          miss;

    logic [1:0]  g_st;
    logic        g_hit;
    logic [1:0]  g_proc;
    logic [1:0]  g_idx;
    logic [2:0]  g_cnt;
    logic        g_full;
    int          g_lat;
    bit          seen;

    cmd_scoreboard #(.ENTRIES(4), .LANES(1), .CMD_W(8), .PROC_W(2)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_flush(flush),
        .i_req_valid(v1), .o_req_ready(r1_ready),
        .i_req_op(op), .i_req_cmd(cmd), .i_req_proc(proc),
        .o_rsp_valid(r1_valid), .o_rsp_status(r1_status), .o_rsp_hit(r1_hit),
        .o_rsp_proc(r1_proc), .o_rsp_idx(r1_idx),
        .o_count(r1_count), .o_full(r1_full), .o_empty(r1_empty)
    );

    cmd_scoreboard #(.ENTRIES(4), .LANES(2), .CMD_W(8), .PROC_W(2)) dut2 (
        .i_clk(clk), .i_rstn(rstn), .i_flush(flush),
        .i_req_valid(v2), .o_req_ready(r2_ready),
        .i_req_op(op), .i_req_cmd(cmd), .i_req_proc(proc),
        .o_rsp_valid(r2_valid), .o_rsp_status(r2_status), .o_rsp_hit(r2_hit),
        .o_rsp_proc(r2_proc), .o_rsp_idx(r2_idx),
        .o_count(r2_count), .o_full(r2_full), .o_empty(r2_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one request to instance `which`, wait (bounded) for its response.
    task automatic req(input int which, input op_e o, input logic [7:0] c, input logic [1:0] p);
        int  n;
        bit  got;
        @(negedge clk);
        op = o; cmd = c; proc = p;
        if (which == 2) v2 = 1'b1; else v1 = 1'b1;
        #1;
        check("req_ready", 32'(which == 2 ? r2_ready : r1_ready), 32'd1);
        @(posedge clk);
        #1;
        v1 = 1'b0; v2 = 1'b0;
        n = 0; got = 1'b0;
        while (!got && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            got = (which == 2) ? r2_valid : r1_valid;
        end
        g_lat = n;
        if (!got) begin
            check("rsp_timeout", 32'd0, 32'd1);
        end
        g_st   = (which == 2) ? r2_status : r1_status;
        g_hit  = (which == 2) ? r2_hit    : r1_hit;
        g_proc = (which == 2) ? r2_proc   : r1_proc;
        g_idx  = (which == 2) ? r2_idx    : r1_idx;
        g_cnt  = (which == 2) ? r2_count  : r1_count;
        g_full = (which == 2) ? r2_full   : r1_full;
        @(posedge clk);
        #1;
        check("rsp_one_cycle", 32'(which == 2 ? r2_valid : r1_valid), 32'd0);
    endtask

    initial begin
        vec = 0; miss = 0;
        rstn = 1'b0; flush = 1'b0; v1 = 1'b0; v2 = 1'b0;
        op = OP_LOOKUP; cmd = '0; proc = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready",  32'(r1_ready), 32'd0);
        check("rst_valid",  32'(r1_valid), 32'd0);
        check("rst_count",  32'(r1_count), 32'd0);
        check("rst_empty",  32'(r1_empty), 32'd1);
        check("rst_full",   32'(r1_full),  32'd0);
        check("rst_count2", 32'(r2_count), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // 1: three inserts fill the lowest free slots
        req(1, OP_INSERT, 8'd4, 2'd1);
        check("ins4_st", 32'(g_st), 32'(ST_OK));  check("ins4_idx", 32'(g_idx), 32'd0);
        check("ins4_lat", 32'(g_lat), 32'd5);
        req(1, OP_INSERT, 8'd6, 2'd2);
        check("ins6_st", 32'(g_st), 32'(ST_OK));  check("ins6_idx", 32'(g_idx), 32'd1);
        check("ins6_lat", 32'(g_lat), 32'd5);
        req(1, OP_INSERT, 8'd8, 2'd3);
        check("ins8_st", 32'(g_st), 32'(ST_OK));  check("ins8_idx", 32'(g_idx), 32'd2);
        check("ins8_lat", 32'(g_lat), 32'd5);     check("ins8_cnt", 32'(g_cnt), 32'd3);

        // 2: lookup hit in group 2 and a miss
        req(1, OP_LOOKUP, 8'd8, 2'd0);
        check("lk8_st", 32'(g_st), 32'(ST_OK));   check("lk8_hit", 32'(g_hit), 32'd1);
        check("lk8_proc", 32'(g_proc), 32'd3);    check("lk8_idx", 32'(g_idx), 32'd2);
        check("lk8_lat", 32'(g_lat), 32'd4);
        req(1, OP_LOOKUP, 8'd5, 2'd0);
        check("lk5_st", 32'(g_st), 32'(ST_MISS)); check("lk5_hit", 32'(g_hit), 32'd0);
        check("lk5_proc", 32'(g_proc), 32'd0);    check("lk5_idx", 32'(g_idx), 32'd0);
        check("lk5_lat", 32'(g_lat), 32'd5);

        // 3: overwrite existing key
        req(1, OP_INSERT, 8'd6, 2'd0);
        check("upd6_st", 32'(g_st), 32'(ST_UPDATED)); check("upd6_idx", 32'(g_idx), 32'd1);
        check("upd6_cnt", 32'(g_cnt), 32'd3);         check("upd6_lat", 32'(g_lat), 32'd5);
        req(1, OP_LOOKUP, 8'd6, 2'd3);
        check("lk6_proc", 32'(g_proc), 32'd0);    check("lk6_idx", 32'(g_idx), 32'd1);
        check("lk6_lat", 32'(g_lat), 32'd3);

        // 4: fill to capacity, then overflow
        req(1, OP_INSERT, 8'd9, 2'd1);
        check("ins9_st", 32'(g_st), 32'(ST_OK));  check("ins9_idx", 32'(g_idx), 32'd3);
        check("ins9_full", 32'(g_full), 32'd1);   check("ins9_cnt", 32'(g_cnt), 32'd4);
        req(1, OP_INSERT, 8'd10, 2'd2);
        check("ins10_st", 32'(g_st), 32'(ST_FULL)); check("ins10_cnt", 32'(g_cnt), 32'd4);
        check("ins10_lat", 32'(g_lat), 32'd5);
        req(1, OP_LOOKUP, 8'd10, 2'd0);
        check("lk10_st", 32'(g_st), 32'(ST_MISS));
        req(1, OP_LOOKUP, 8'd4, 2'd0);
        check("lk4_proc", 32'(g_proc), 32'd1);    check("lk4_idx", 32'(g_idx), 32'd0);
        check("lk4_lat", 32'(g_lat), 32'd2);

        // 5: remove frees a slot that the next insert reuses
        req(1, OP_REMOVE, 8'd6, 2'd0);
        check("rm6_st", 32'(g_st), 32'(ST_OK));   check("rm6_cnt", 32'(g_cnt), 32'd3);
        check("rm6_idx", 32'(g_idx), 32'd1);      check("rm6_lat", 32'(g_lat), 32'd3);
        req(1, OP_LOOKUP, 8'd6, 2'd0);
        check("lk6b_st", 32'(g_st), 32'(ST_MISS));
        req(1, OP_REMOVE, 8'd6, 2'd0);
        check("rm6b_st", 32'(g_st), 32'(ST_MISS)); check("rm6b_cnt", 32'(g_cnt), 32'd3);
        req(1, OP_INSERT, 8'd11, 2'd2);
        check("ins11_st", 32'(g_st), 32'(ST_OK)); check("ins11_idx", 32'(g_idx), 32'd1);
        check("ins11_cnt", 32'(g_cnt), 32'd4);

        // LANES=2: two groups, hit latency g+2, insert/miss latency 3
        req(2, OP_INSERT, 8'd1, 2'd1);
        check("l2_ins1_idx", 32'(g_idx), 32'd0);  check("l2_ins1_lat", 32'(g_lat), 32'd3);
        req(2, OP_INSERT, 8'd2, 2'd2);
        check("l2_ins2_idx", 32'(g_idx), 32'd1);
        req(2, OP_INSERT, 8'd3, 2'd3);
        check("l2_ins3_idx", 32'(g_idx), 32'd2);
        req(2, OP_INSERT, 8'd5, 2'd0);
        check("l2_ins5_idx", 32'(g_idx), 32'd3);  check("l2_ins5_full", 32'(g_full), 32'd1);
        req(2, OP_LOOKUP, 8'd5, 2'd1);
        check("l2_lk5_st", 32'(g_st), 32'(ST_OK)); check("l2_lk5_idx", 32'(g_idx), 32'd3);
        check("l2_lk5_proc", 32'(g_proc), 32'd0);  check("l2_lk5_lat", 32'(g_lat), 32'd3);
        req(2, OP_LOOKUP, 8'd2, 2'd0);
        check("l2_lk2_idx", 32'(g_idx), 32'd1);   check("l2_lk2_proc", 32'(g_proc), 32'd2);
        check("l2_lk2_lat", 32'(g_lat), 32'd2);
        req(2, OP_LOOKUP, 8'd7, 2'd0);
        check("l2_lk7_st", 32'(g_st), 32'(ST_MISS)); check("l2_lk7_lat", 32'(g_lat), 32'd3);

        // 6: flush during scan of a lookup aborts it
        @(negedge clk);
        op = OP_LOOKUP; cmd = 8'd99; v1 = 1'b1;
        @(posedge clk);
        #1;
        v1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (r1_valid) seen = 1'b1;
        end
        check("fl_no_rsp", 32'(seen), 32'd0);
        check("fl_count", 32'(r1_count), 32'd0);
        check("fl_empty", 32'(r1_empty), 32'd1);
        check("fl_count2", 32'(r2_count), 32'd0);
        check("fl_ready", 32'(r1_ready), 32'd1);

        // Flush in IDLE blocks acceptance
        @(negedge clk);
        flush = 1'b1; v1 = 1'b1; op = OP_INSERT; cmd = 8'd50; proc = 2'd1;
        #1;
        check("fl_idle_ready", 32'(r1_ready), 32'd0);
        @(negedge clk);
        flush = 1'b0; v1 = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (r1_valid) seen = 1'b1;
        end
        check("fl_idle_no_rsp", 32'(seen), 32'd0);
        check("fl_idle_count", 32'(r1_count), 32'd0);

        // Entries are gone after flush
        req(1, OP_LOOKUP, 8'd4, 2'd0);
        check("post_fl_st", 32'(g_st), 32'(ST_MISS));
        check("post_fl_lat", 32'(g_lat), 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
